// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, flag bit
// positions and the issue FSM state type.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int FLG_OV   = 2;
    localparam int FLG_SIGN = 1;
    localparam int FLG_ZERO = 0;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    // The ALU only produces a meaningful overflow flag for add/sub.
    function automatic logic is_arith(input logic [1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Small response FIFO; push is accepted at full when a pop happens in the
// same cycle. Storage is reset so the head reads zero out of reset.
module alu_rsp_fifo #(
    parameter int width = 19,
    parameter int depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [width-1:0]       wdata,
    input  logic                   pop,
    output logic [width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(depth));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of a combinational ALU: registers operands,
// captures the ALU result a cycle later into a response FIFO, keeps acc/sticky_ov.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int data_width = 16,
    parameter int depth      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [data_width-1:0] cmd_a,
    input  logic [data_width-1:0] cmd_b,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_acc,
    output logic [data_width-1:0] alu_a,
    output logic [data_width-1:0] alu_b,
    output logic [1:0]            alu_control,
    input  logic [data_width-1:0] alu_r,
    input  logic                  alu_ov,
    input  logic                  alu_sign,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_r,
    output logic [2:0]            rsp_flags,
    output logic [data_width-1:0] acc,
    output logic                  sticky_ov,
    input  logic                  clr_sticky
);

    localparam int CW = $clog2(depth) + 1;

    state_t                  state, state_nxt;
    logic                    load, push, can_push;
    logic                    fifo_full, fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [2:0]              cap_flags;
    logic [data_width+2:0]   fifo_rdata;

    assign can_push = (fifo_count < CW'(depth)) || (fifo_full && rsp_ready);

    always_comb begin
        cap_flags           = '0;
        cap_flags[FLG_OV]   = alu_ov & is_arith(alu_control);
        cap_flags[FLG_SIGN] = alu_sign;
        cap_flags[FLG_ZERO] = alu_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        load      = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load      = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC, HOLD: begin
                // Operands stay registered through HOLD, so the ALU output is still valid.
                if (can_push) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= ALU_ADD;
        end else if (load) begin
            alu_a       <= cmd_acc ? acc : cmd_a;
            alu_b       <= cmd_b;
            alu_control <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            sticky_ov <= 1'b0;
        end else begin
            if (push) acc <= alu_r;
            // A capture with overflow beats a concurrent clear.
            if (push && cap_flags[FLG_OV]) sticky_ov <= 1'b1;
            else if (clr_sticky)           sticky_ov <= 1'b0;
        end
    end

    alu_rsp_fifo #(
        .width (data_width + 3),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({cap_flags, alu_r}),
        .pop   (rsp_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_r     = fifo_rdata[data_width-1:0];
    assign rsp_flags = fifo_rdata[data_width +: 3];

endmodule
